// File: rtl/mf8_pkg.sv
// mf8_pkg -- shared definitions for the mf8 core.
//   ADDR_W   : program-memory word-address width
//   OP_RJMP  : opcode nibble (word[15:12]) of the relative jump RJMP k
//   state_t  : instruction-fetch sequencing states
package mf8_pkg;

  localparam int         ADDR_W  = 12;
  localparam logic [3:0] OP_RJMP = 4'b1100;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,  // pipeline empty, ROM read of NPC in flight
    ST_RUN    = 2'd1,  // ROM_Data holds the instruction at PC
    ST_BUBBLE = 2'd2   // jump target read in flight, nothing to execute
  } state_t;

endpackage

// File: rtl/mf8_rjmp_dec.sv
// mf8_rjmp_dec -- combinational RJMP detector.
//   word    : 16-bit instruction word
//   is_rjmp : word is RJMP k
//   offset  : k + 1 (mod 2^ADDR_W), the PC offset the sequencer adds
module mf8_rjmp_dec
  import mf8_pkg::*;
(
  input  logic [15:0]       word,
  output logic              is_rjmp,
  output logic [ADDR_W-1:0] offset
);

  assign is_rjmp = (word[15:12] == OP_RJMP);

  // k already spans the full 12-bit address, so sign extension to 12 bits is
  // the identity; the +1 wraps naturally, giving k=-1 an offset of 0.
  assign offset = word[ADDR_W-1:0] + ADDR_W'(1);

endmodule

// File: rtl/mf8_ifetch.sv
// mf8_ifetch -- instruction fetch stage for the mf8 core.
//   Clk, Reset_n  : clock, asynchronous active-low reset
//   PC, NPC       : current / next program counter from the sequencer
//   ROM_Addr      : synchronous ROM address (always NPC)
//   ROM_Data      : ROM word, valid one cycle after its address
//   Stall         : execute-stage hold request
//   Inst          : instruction at PC (zero when not valid)
//   Inst_Valid    : Inst is executable this cycle
//   Offs_Out      : PC offset to the sequencer, selected by RJmp
//   RJmp          : take Offs_Out as the PC offset
//   Pause         : hold PC (when RJmp is 0)
//   Inst_Count    : retired-instruction counter (wraps)
// RJMP is resolved here so a jump costs two cycles: the RUN cycle that issues
// it and one BUBBLE while the target word is read.
module mf8_ifetch
  import mf8_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] NPC,
  output logic [ADDR_W-1:0] ROM_Addr,
  input  logic [15:0]       ROM_Data,
  input  logic              Stall,
  output logic [15:0]       Inst,
  output logic              Inst_Valid,
  output logic [ADDR_W-1:0] Offs_Out,
  output logic              RJmp,
  output logic              Pause,
  output logic [15:0]       Inst_Count
);

  state_t            state;
  logic              is_rjmp;
  logic [ADDR_W-1:0] rjmp_offs;

  // PC is part of the sequencer interface but fetch decisions never need it.
  logic unused_pc;
  assign unused_pc = ^PC;

  mf8_rjmp_dec u_rjmp_dec (
    .word    (ROM_Data),
    .is_rjmp (is_rjmp),
    .offset  (rjmp_offs)
  );

  // The ROM always fetches the word the sequencer will move to next.
  assign ROM_Addr = NPC;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    Inst       = 16'h0000;
    Inst_Valid = 1'b0;
    RJmp       = 1'b0;
    Offs_Out   = '0;
    Pause      = 1'b1;
    if (state == ST_RUN) begin
      Inst       = ROM_Data;
      Inst_Valid = 1'b1;
      if (!Stall) begin
        Pause = 1'b0;
        if (is_rjmp) begin
          RJmp     = 1'b1;
          Offs_Out = rjmp_offs;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_FILL;
      Inst_Count <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      case (state)
        ST_FILL:   state <= ST_RUN;
        ST_RUN: begin
          if (!Stall) begin
            Inst_Count <= Inst_Count + 16'd1;
            if (is_rjmp) state <= ST_BUBBLE;
          end
        end
        ST_BUBBLE: state <= ST_RUN;
        default:   state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: doc/mf8_ifetch.md
MF8_IFETCH -- requirements
Module: mf8_ifetch

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port PC, input, 12 bits: current program counter from the sequencer.
REQ-004 SHALL have port NPC, input, 12 bits: next program counter from the sequencer.
REQ-005 SHALL have port ROM_Addr, output, 12 bits: program ROM word address.
REQ-006 SHALL have port ROM_Data, input, 16 bits: ROM word; synchronous ROM, data for an address is valid one cycle after that address is presented.
REQ-007 SHALL have port Stall, input, 1 bit: execute-stage hold request.
REQ-008 SHALL have port Inst, output, 16 bits: instruction word at PC.
REQ-009 SHALL have port Inst_Valid, output, 1 bit: Inst is an executable instruction this cycle.
REQ-010 SHALL have port Offs_Out, output, 12 bits: PC offset to the sequencer.
REQ-011 SHALL have port RJmp, output, 1 bit: selects Offs_Out as the sequencer offset.
REQ-012 SHALL have port Pause, output, 1 bit: sequencer holds PC when 1 and RJmp is 0.
REQ-013 SHALL have port Inst_Count, output, 16 bits: retired-instruction counter.

Function
REQ-014 SHALL drive ROM_Addr = NPC combinationally in every state.
REQ-015 SHALL implement states FILL, RUN and BUBBLE.
REQ-016 SHALL, in FILL: Pause=1, RJmp=0, Inst_Valid=0, Offs_Out=0; next state RUN.
REQ-017 SHALL, in RUN: Inst=ROM_Data, Inst_Valid=1.
REQ-018 SHALL, in RUN with Stall=1: Pause=1, RJmp=0, remain RUN; no jump is taken, even for an RJMP word.
REQ-019 SHALL, in RUN with Stall=0 and ROM_Data[15:12]=4'b1100 (RJMP k):
- RJmp=1
- Offs_Out = sign-extended k[11:0] + 1, modulo 2^12
- next state BUBBLE.
REQ-020 SHALL, in RUN with Stall=0 and a non-RJMP word: Pause=0, RJmp=0, Offs_Out=0, remain RUN.
REQ-021 SHALL, in BUBBLE: Inst_Valid=0, Pause=1, RJmp=0, Offs_Out=0; next state RUN regardless of Stall (2-cycle RJMP timing).
REQ-022 SHALL drive Inst=16'h0000 whenever Inst_Valid=0.
REQ-023 SHALL increment Inst_Count by 1 on each edge where state=RUN and Stall=0; wrap 16'hFFFF -> 16'h0000.
REQ-024 SHALL treat RJMP k=12'hFFF (Offs_Out=0) as a legal self-loop: BUBBLE, then RUN re-executes the same word.
REQ-025 SHALL rely on 12-bit wrap-around for jump targets (e.g. PC=12'hFFE, k=1 -> target 12'h000); no range check.
REQ-026 SHALL treat Stall while in FILL or BUBBLE as no effect on that state's outputs or transition.

Reset
REQ-027 SHALL, while Reset_n=0: state=FILL, Inst_Count=0, Inst=0, Inst_Valid=0, RJmp=0, Offs_Out=0, Pause=1.
REQ-028 SHALL, on Reset_n assertion mid-RUN or mid-BUBBLE, abort immediately to FILL with no pending jump retained.
REQ-029 SHALL make the first valid Inst after reset release the word at address 0, presented in the cycle after FILL.

Structure
REQ-030 SHALL place in the shared mf8 package:
- state encoding
- RJMP opcode constant 4'b1100
- 12-bit address width constant.
REQ-031 SHALL use one combinational sub-module, mf8_rjmp_dec, with:
- input: 16-bit word
- outputs: is_rjmp flag and 12-bit offset (k+1).
REQ-032 SHALL keep Inst, Inst_Valid, RJmp, Offs_Out and Pause combinational from state, Stall and ROM_Data; state and Inst_Count are the only registers.

Verification
REQ-033 SHALL cover the reset release scenario. Stimulus: release Reset_n with ROM[0]=16'h0000. Required response:
- cycle 1: FILL, Pause=1, ROM_Addr=0
- cycle 2: Inst=0x0000, Inst_Valid=1, Inst_Count=0 before the edge and 1 after it.
REQ-034 SHALL cover a forward RJMP. Stimulus: PC=12'h010, ROM[0x010]=16'hC005. Required response:
- RJmp=1, Offs_Out=12'h006, ROM_Addr=12'h016
- next cycle: Inst_Valid=0
- following cycle: Inst=ROM[0x016].
REQ-035 SHALL cover a backward RJMP. Stimulus: PC=12'h001, ROM[1]=16'hCFFD (k=-3). Required response:
- Offs_Out=12'hFFE
- target PC wraps to 12'hFFF.
REQ-036 SHALL cover Stall on an RJMP word. Stimulus: Stall=1 for 3 cycles. Required response:
- during Stall: Pause=1, RJmp=0, Inst held, Inst_Count unchanged
- on release: RJmp=1 taken once.
REQ-037 SHALL cover a self-loop. Stimulus: ROM word 16'hCFFF. Required response:
- alternates RUN/BUBBLE on the same PC
- Inst_Count +1 per two cycles.
REQ-038 SHALL cover mid-operation reset. Stimulus: assert Reset_n in BUBBLE. Required response:
- all outputs at reset values asynchronously
- FILL sequence repeats on release.
